// File: rtl/matmul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// matmul_seq_ctrl
//
// Byte-serial front end for the NxN matrix-multiply datapath. Operand bytes
// arrive on a valid/ready stream (A row-major, then B row-major). Once both
// operands are held, the datapath is launched, its result matrix is captured
// on dp_done, and the result is streamed out little-endian, BPE bytes per
// element, zero-filled above CW bits.
//
// Optional build macro: MATSEQ_TIMEOUT_EN
//   Adds a WAIT timeout of TIMEOUT cycles. On expiry the controller enters ERR,
//   raises the sticky err flag and streams an all-zero frame. Without the
//   macro WAIT has no bound and err is tied low.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   soft_clr              synchronous abort back to LOAD (highest priority)
//   in_data/valid/ready   operand byte stream
//   dp_a, dp_b            packed operand matrices, element i at [i*DW +: DW]
//   dp_start              one-cycle datapath launch
//   dp_done, dp_c         datapath completion pulse and packed result
//   out_data/valid/ready  result byte stream
//   busy                  high in START/WAIT/UNLOAD
//   frame_done            pulse on the handshake of the last result byte
//   err                   sticky timeout flag
// -----------------------------------------------------------------------------
// state  | meaning
// -------+--------------------------------------------------------------
// LOAD   | accepting 2*N*N operand bytes
// START  | dp_start pulse, operands frozen
// WAIT   | waiting for dp_done (bounded only with MATSEQ_TIMEOUT_EN)
// UNLOAD | streaming captured result bytes
// ERR    | timeout: streaming an all-zero frame with err set
// -----------------------------------------------------------------------------
module matmul_seq_ctrl #(
    parameter int N       = 3,
    parameter int DW      = 8,
    parameter int CW      = 18,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 soft_clr,
    input  logic [DW-1:0]        in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [N*N*DW-1:0]    dp_a,
    output logic [N*N*DW-1:0]    dp_b,
    output logic                 dp_start,
    input  logic                 dp_done,
    input  logic [N*N*CW-1:0]    dp_c,
    output logic [7:0]           out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 err
);

    localparam int NE    = N * N;
    localparam int NB_IN = 2 * NE;
    localparam int BPE   = (CW + 7) / 8;
    localparam int LDW   = $clog2(NB_IN);
    localparam int ELW   = (NE > 1) ? $clog2(NE) : 1;
    localparam int BSW   = (BPE > 1) ? $clog2(BPE) : 1;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("matmul_seq_ctrl: TIMEOUT must be at least 1");
    end

    typedef enum logic [2:0] {
        ST_LOAD   = 3'd0,
        ST_START  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_UNLOAD = 3'd3,
        ST_ERR    = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [LDW-1:0]       ld_cnt;
    logic [ELW-1:0]       el_cnt;
    logic [BSW-1:0]       bsel;
    logic [NE*DW-1:0]     a_q;
    logic [NE*DW-1:0]     b_q;
    logic [NE*CW-1:0]     c_q;

    logic                 in_fire;
    logic                 out_fire;
    logic                 last_in;
    logic                 last_byte_of_elem;
    logic                 last_out;
    logic                 sending;
    logic [BPE*8-1:0]     elem_ext;
    logic [7:0]           res_byte;

    // Handshakes are derived from the state register directly so that the
    // output decode below does not feed back into itself.
    assign sending           = (state_q == ST_UNLOAD) || (state_q == ST_ERR);
    assign in_fire           = (state_q == ST_LOAD) && in_valid && !soft_clr;
    assign out_fire          = sending && out_ready && !soft_clr;
    assign last_in           = (ld_cnt == LDW'(NB_IN - 1));
    assign last_byte_of_elem = (bsel == BSW'(BPE - 1));
    assign last_out          = last_byte_of_elem && (el_cnt == ELW'(NE - 1));

    assign dp_a       = a_q;
    assign dp_b       = b_q;
    assign frame_done = out_fire && last_out;

`ifdef MATSEQ_TIMEOUT_EN
    localparam int TMW = $clog2(TIMEOUT + 1);
    logic [TMW-1:0] tmo_cnt;
    logic           err_q;
    logic           tmo_hit;

    // Loaded in START, so the bound counts WAIT cycles only.
    assign tmo_hit = (state_q == ST_WAIT) && !dp_done && (tmo_cnt == TMW'(1));
    assign err     = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else if (soft_clr) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state_q == ST_START) begin
                tmo_cnt <= TMW'(TIMEOUT);
            end else if (state_q == ST_WAIT && tmo_cnt != '0) begin
                tmo_cnt <= tmo_cnt - TMW'(1);
            end
            if (tmo_hit) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        dp_start  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            ST_LOAD: begin
                in_ready = 1'b1;
                if (in_fire && last_in) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                dp_start = 1'b1;
                busy     = 1'b1;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                busy = 1'b1;
                if (dp_done) begin
                    state_d = ST_UNLOAD;
                end
`ifdef MATSEQ_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_d = ST_ERR;
                end
`endif
            end
            ST_UNLOAD: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_fire && last_out) begin
                    state_d = ST_LOAD;
                end
            end
            ST_ERR: begin
                out_valid = 1'b1;
                if (out_fire && last_out) begin
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
        if (soft_clr) begin
            state_d = ST_LOAD;
        end
    end

    // Operand capture and load byte counter. Operands only change in LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_cnt <= '0;
            a_q    <= '0;
            b_q    <= '0;
        end else if (soft_clr) begin
            ld_cnt <= '0;
        end else if (in_fire) begin
            for (int i = 0; i < NE; i++) begin
                if (ld_cnt == LDW'(i)) begin
                    a_q[i*DW +: DW] <= in_data;
                end
                if (ld_cnt == LDW'(NE + i)) begin
                    b_q[i*DW +: DW] <= in_data;
                end
            end
            ld_cnt <= last_in ? '0 : ld_cnt + LDW'(1);
        end
    end

    // Result capture (WAIT only) and unload element/byte counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q    <= '0;
            el_cnt <= '0;
            bsel   <= '0;
        end else if (soft_clr) begin
            el_cnt <= '0;
            bsel   <= '0;
        end else begin
            if (state_q == ST_WAIT && dp_done) begin
                c_q <= dp_c;
            end
            if (out_fire) begin
                if (last_byte_of_elem) begin
                    bsel   <= '0;
                    el_cnt <= last_out ? '0 : el_cnt + ELW'(1);
                end else begin
                    bsel <= bsel + BSW'(1);
                end
            end
        end
    end

    // Byte select of the current result element, zero-extended to BPE bytes.
    always_comb begin
        elem_ext = '0;
        res_byte = '0;
        for (int i = 0; i < NE; i++) begin
            if (el_cnt == ELW'(i)) begin
                elem_ext[CW-1:0] = c_q[i*CW +: CW];
            end
        end
        for (int k = 0; k < BPE; k++) begin
            if (bsel == BSW'(k)) begin
                res_byte = elem_ext[k*8 +: 8];
            end
        end
    end

    // ERR streams zeros; outside the unload states the bus idles at zero.
    assign out_data = (state_q == ST_UNLOAD) ? res_byte : 8'h00;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
module tb_matmul_seq_ctrl;

    localparam int N  = 3;
    localparam int DW = 8;
    localparam int CW = 18;
    localparam int NE = N * N;
    localparam int NB = 27;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               soft_clr = 1'b0;
    logic [DW-1:0]      in_data = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [NE*DW-1:0]   dp_a;
    logic [NE*DW-1:0]   dp_b;
    logic               dp_start;
    logic               dp_done = 1'b0;
    logic [NE*CW-1:0]   dp_c = '0;
    logic [7:0]         out_data;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic               busy;
    logic               frame_done;
    logic               err;

    int                 ea [NE];
    int                 eb [NE];
    logic [7:0]         exp_bytes [NB];
    int                 n_chk = 0;
    int                 n_pass = 0;
    int                 dp_starts = 0;
    int                 dp_cnt = 0;
    bit                 dp_en = 1'b1;

    matmul_seq_ctrl #(.N(N), .DW(DW), .CW(CW), .TIMEOUT(15)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .soft_clr   (soft_clr),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dp_a       (dp_a),
        .dp_b       (dp_b),
        .dp_start   (dp_start),
        .dp_done    (dp_done),
        .dp_c       (dp_c),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .frame_done (frame_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference: C = A x B in plain integer arithmetic.
    function automatic int elem_c(input int e);
        int s = 0;
        for (int k = 0; k < N; k++) s += ea[(e / N) * N + k] * eb[k * N + (e % N)];
        return s;
    endfunction

    function automatic logic [NE*CW-1:0] product();
        logic [NE*CW-1:0] v = '0;
        for (int e = 0; e < NE; e++) v[e*CW +: CW] = CW'(elem_c(e));
        return v;
    endfunction

    function automatic logic [NE*CW-1:0] rand_c();
        logic [NE*CW-1:0] v = '0;
        for (int e = 0; e < NE; e++) v[e*CW +: CW] = CW'($urandom);
        return v;
    endfunction

    function automatic logic [NE*DW-1:0] pack_ops(input bit sel_b);
        logic [NE*DW-1:0] v = '0;
        for (int i = 0; i < NE; i++) v[i*DW +: DW] = DW'(sel_b ? eb[i] : ea[i]);
        return v;
    endfunction

    task automatic build_expected(input bit zeros);
        for (int e = 0; e < NE; e++) begin
            int c = zeros ? 0 : elem_c(e);
            for (int b = 0; b < 3; b++) exp_bytes[e*3 + b] = 8'((c >> (8 * b)) & 255);
        end
    endtask

    // Datapath stand-in: pulses dp_done 3 cycles after dp_start with the true
    // product; otherwise dp_c is noise and idle-time dp_done pulses are noise.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_cnt  = 0;
            dp_done = 1'b0;
        end else begin
            dp_done = 1'b0;
            dp_c    = rand_c();
            if (dp_start) begin
                dp_starts++;
                if (dp_en) dp_cnt = 3;
            end else if (dp_cnt > 0) begin
                dp_cnt--;
                if (dp_cnt == 0) begin
                    dp_done = 1'b1;
                    dp_c    = product();
                end
            end else if (!busy && $urandom_range(0, 7) == 0) begin
                dp_done = 1'b1;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        int gap = $urandom_range(0, 2);
        repeat (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_val("in_ready", in_ready, 1'b1);
        @(posedge clk);
    endtask

    task automatic send_bytes(input int count, input int starts0);
        for (int j = 0; j < count; j++) begin
            if (j == 2 * NE - 1) check_val("no_early_start", dp_starts, starts0);
            send_byte(8'(j < NE ? ea[j] : eb[j - NE]));
        end
    endtask

    task automatic recv_frame(input int stop_at, input bit err_mode);
        int idx = 0;
        int n = 0;
        out_ready = 1'b0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val("out_valid_rise", out_valid, 1'b1);
        if (!out_valid) return;
        n = 0;
        while (idx < NB && n < 2000) begin
            if (idx == stop_at) return;
            check_val("out_valid", out_valid, 1'b1);
            check_val("out_data", out_data, exp_bytes[idx]);
            check_val("busy_unload", busy, !err_mode);
            out_ready = 1'($urandom_range(0, 1));
            #1;
            check_val("frame_done", frame_done, out_ready && idx == NB - 1);
            if (out_ready) idx++;
            @(negedge clk);
            n++;
        end
        check_val("byte_count", idx, NB);
        check_val("out_valid_end", out_valid, 1'b0);
        check_val("in_ready_end", in_ready, 1'b1);
        check_val("busy_end", busy, 1'b0);
        check_val("frame_done_end", frame_done, 1'b0);
        out_ready = 1'b0;
    endtask

    task automatic start_frame(input int starts0);
        send_bytes(2 * NE, starts0);
        @(negedge clk);
        in_valid = 1'b0;
        check_val("dp_start_hi", dp_start, 1'b1);
        check_val("dp_a", dp_a, pack_ops(1'b0));
        check_val("dp_b", dp_b, pack_ops(1'b1));
        check_val("busy_start", busy, 1'b1);
        @(negedge clk);
        check_val("dp_start_lo", dp_start, 1'b0);
    endtask

    task automatic run_frame();
        int starts0 = dp_starts;
        build_expected(1'b0);
        start_frame(starts0);
        recv_frame(NB, 1'b0);
        check_val("dp_start_count", dp_starts - starts0, 1);
        check_val("err_clean", err, 1'b0);
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NE; i++) begin
            ea[i] = $urandom_range(0, 255);
            eb[i] = $urandom_range(0, 255);
        end
    endtask

    initial begin
        int starts0;
        int n;
        repeat (2) @(negedge clk);
        check_val("rst_in_ready", in_ready, 1'b1);
        check_val("rst_out_valid", out_valid, 1'b0);
        check_val("rst_out_data", out_data, 8'h00);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_dp_start", dp_start, 1'b0);
        check_val("rst_dp_a", dp_a, '0);
        check_val("rst_err", err, 1'b0);
        rst_n = 1'b1;

        // Identity x 1..9
        for (int i = 0; i < NE; i++) begin
            ea[i] = (i % (N + 1) == 0) ? 1 : 0;
            eb[i] = i + 1;
        end
        run_frame();

        // All 255: every element 0x2FA03
        for (int i = 0; i < NE; i++) begin
            ea[i] = 255;
            eb[i] = 255;
        end
        run_frame();

        for (int f = 0; f < 4; f++) begin
            rand_ops();
            run_frame();
        end

        // Abort after 10 bytes, then a complete new frame
        rand_ops();
        starts0 = dp_starts;
        send_bytes(10, starts0);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'hAA;
        soft_clr = 1'b1;
        check_val("clr_in_ready", in_ready, 1'b1);
        @(negedge clk);
        soft_clr = 1'b0;
        in_valid = 1'b0;
        check_val("clr_busy", busy, 1'b0);
        check_val("clr_no_start", dp_starts, starts0);
        rand_ops();
        run_frame();

        // Reset during unload after 5 bytes
        rand_ops();
        build_expected(1'b0);
        start_frame(dp_starts);
        recv_frame(5, 1'b0);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_out_valid", out_valid, 1'b0);
        check_val("mid_rst_out_data", out_data, 8'h00);
        check_val("mid_rst_busy", busy, 1'b0);
        check_val("mid_rst_in_ready", in_ready, 1'b1);
        check_val("mid_rst_dp_a", dp_a, '0);
        check_val("mid_rst_frame_done", frame_done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b0;
        rand_ops();
        run_frame();

        // Datapath never answers
        dp_en = 1'b0;
        rand_ops();
        start_frame(dp_starts);
`ifdef MATSEQ_TIMEOUT_EN
        n = 1;
        while (!err && n < 60) begin
            @(negedge clk);
            n++;
        end
        check_val("timeout_cycles", n, 16);
        check_val("err_busy", busy, 1'b0);
        build_expected(1'b1);
        recv_frame(NB, 1'b1);
        check_val("err_sticky", err, 1'b1);
        soft_clr = 1'b1;
        @(negedge clk);
        soft_clr = 1'b0;
        check_val("err_cleared", err, 1'b0);
`else
        n = 0;
        repeat (60) @(negedge clk);
        check_val("wait_busy", busy, 1'b1);
        check_val("wait_err", err, 1'b0);
        check_val("wait_out_valid", out_valid, 1'b0);
        soft_clr = 1'b1;
        @(negedge clk);
        soft_clr = 1'b0;
        check_val("wait_clr_busy", busy, 1'b0);
        check_val("wait_clr_in_ready", in_ready, 1'b1);
`endif
        dp_en = 1'b1;
        rand_ops();
        run_frame();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
